// File: rtl/usbf_ep_pktbuf_pkg.sv
// Default configuration and helpers shared by the endpoint packet buffer
// and its RAM.
package usbf_ep_pktbuf_pkg;

   localparam int DEF_EP_NUM = 4;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 9;

   localparam logic [63:0] DEF_EP_BASE = {16'd192, 16'd128, 16'd64, 16'd0};
   localparam logic [63:0] DEF_EP_SIZE = {16'd64, 16'd64, 16'd64, 16'd64};

   function automatic int ep_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usbf_ep_pktbuf_dpram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The array has no reset; only the read register does.
module usbf_dpram
   import usbf_ep_pktbuf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register holds its value while re is low.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/usbf_ep_pktbuf.sv
// Multi-endpoint packet buffer: per-EP circular regions in one shared RAM,
// with packet-level commit/abort on the write side.
module usbf_ep_pktbuf
   import usbf_ep_pktbuf_pkg::*;
#(
   parameter int                    EP_NUM  = DEF_EP_NUM,
   parameter int                    DATA_W  = DEF_DATA_W,
   parameter int                    ADDR_W  = DEF_ADDR_W,
   parameter logic [16*EP_NUM-1:0]  EP_BASE = DEF_EP_BASE,
   parameter logic [16*EP_NUM-1:0]  EP_SIZE = DEF_EP_SIZE,
   localparam int                   EP_W    = ep_sel_w(EP_NUM),
   localparam int                   CNT_W   = ADDR_W + 1
) (
   input  logic                      hclk_i,
   input  logic                      rst_i,
   input  logic [EP_NUM-1:0]         flush_i,
   input  logic                      wr_en_i,
   input  logic [EP_W-1:0]           wr_ep_i,
   input  logic [DATA_W-1:0]         wr_data_i,
   input  logic                      wr_commit_i,
   input  logic                      wr_abort_i,
   input  logic                      rd_en_i,
   input  logic [EP_W-1:0]           rd_ep_i,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      rd_valid_o,
   output logic [EP_NUM-1:0]         ep_empty_o,
   output logic [EP_NUM-1:0]         ep_full_o,
   output logic [EP_NUM*CNT_W-1:0]   ep_level_o,
   output logic [EP_NUM-1:0]         ovf_o
);

   logic [EP_NUM-1:0]        we_ep;
   logic [EP_NUM-1:0]        re_ep;
   logic [EP_NUM*ADDR_W-1:0] waddr_ep;
   logic [EP_NUM*ADDR_W-1:0] raddr_ep;
   logic                     ram_we;
   logic                     ram_re;
   logic [ADDR_W-1:0]        ram_waddr;
   logic [ADDR_W-1:0]        ram_raddr;

   for (genvar i = 0; i < EP_NUM; i++) begin : g_ep
      localparam int BASE_I = int'(EP_BASE[16*i +: 16]);
      localparam int SIZE_I = int'(EP_SIZE[16*i +: 16]);
      localparam logic [CNT_W-1:0]  SZ     = CNT_W'(SIZE_I);
      localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_I);

      if (SIZE_I < 1 || SIZE_I > (1 << ADDR_W) || BASE_I + SIZE_I > (1 << ADDR_W)) begin : g_bad_size
         $error("usbf_ep_pktbuf: EP region does not fit the RAM");
      end
      for (genvar j = i + 1; j < EP_NUM; j++) begin : g_ovl
         localparam int BASE_J = int'(EP_BASE[16*j +: 16]);
         localparam int SIZE_J = int'(EP_SIZE[16*j +: 16]);
         if (BASE_I < BASE_J + SIZE_J && BASE_J < BASE_I + SIZE_I) begin : g_bad_ovl
            $error("usbf_ep_pktbuf: EP regions overlap");
         end
      end

      logic [CNT_W-1:0] wptr, cptr, rptr, ccnt, pcnt;
      logic [CNT_W-1:0] wptr_inc, rptr_inc, wptr_nxt, pcnt_nxt, rd_dec;
      logic             sel_w, sel_r, full, commit, abort, ovf;

      // Out-of-range endpoint selects match no slice and are ignored.
      assign sel_w    = (wr_ep_i == EP_W'(i));
      assign sel_r    = (rd_ep_i == EP_W'(i));
      assign full     = (ccnt + pcnt == SZ);
      assign commit   = wr_commit_i && sel_w;
      assign abort    = wr_abort_i && sel_w;
      assign we_ep[i] = wr_en_i && sel_w && !full && !flush_i[i];
      assign re_ep[i] = rd_en_i && sel_r && (ccnt != '0) && !flush_i[i];

      assign wptr_inc = (wptr == SZ - 1'b1) ? '0 : wptr + 1'b1;
      assign rptr_inc = (rptr == SZ - 1'b1) ? '0 : rptr + 1'b1;
      assign wptr_nxt = we_ep[i] ? wptr_inc : wptr;
      assign pcnt_nxt = pcnt + CNT_W'(we_ep[i]);
      assign rd_dec   = CNT_W'(re_ep[i]);

      assign waddr_ep[i*ADDR_W +: ADDR_W] = BASE_A + wptr[ADDR_W-1:0];
      assign raddr_ep[i*ADDR_W +: ADDR_W] = BASE_A + rptr[ADDR_W-1:0];

      always_ff @(posedge hclk_i) begin
         if (rst_i || flush_i[i]) begin
            wptr <= '0;
            cptr <= '0;
            rptr <= '0;
            ccnt <= '0;
            pcnt <= '0;
            ovf  <= 1'b0;
         end else begin
            ovf <= wr_en_i && sel_w && full;
            if (re_ep[i]) rptr <= rptr_inc;
            if (abort) begin
               wptr <= cptr;
               pcnt <= '0;
               ccnt <= ccnt - rd_dec;
            end else if (commit) begin
               wptr <= wptr_nxt;
               cptr <= wptr_nxt;
               pcnt <= '0;
               ccnt <= ccnt + pcnt_nxt - rd_dec;
            end else begin
               wptr <= wptr_nxt;
               pcnt <= pcnt_nxt;
               ccnt <= ccnt - rd_dec;
            end
         end
      end

      assign ep_empty_o[i]                  = (ccnt == '0);
      assign ep_full_o[i]                   = full;
      assign ep_level_o[i*CNT_W +: CNT_W]   = ccnt;
      assign ovf_o[i]                       = ovf;
   end

   // At most one EP is selected per port, so an AND-OR mux suffices.
   always_comb begin
      ram_waddr = '0;
      ram_raddr = '0;
      for (int i = 0; i < EP_NUM; i++) begin
         if (we_ep[i]) ram_waddr = ram_waddr | waddr_ep[i*ADDR_W +: ADDR_W];
         if (re_ep[i]) ram_raddr = ram_raddr | raddr_ep[i*ADDR_W +: ADDR_W];
      end
   end

   assign ram_we = |we_ep;
   assign ram_re = |re_ep;

   always_ff @(posedge hclk_i) begin
      if (rst_i) rd_valid_o <= 1'b0;
      else       rd_valid_o <= ram_re;
   end

   usbf_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (hclk_i),
      .rst   (rst_i),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (wr_data_i),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (rd_data_o)
   );

endmodule

// File: tb/tb_usbf_ep_pktbuf.sv
// Bench for usbf_ep_pktbuf: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_usbf_ep_pktbuf;

   localparam int LW = 10;
   localparam logic [63:0] BASE = {16'd300, 16'd200, 16'd100, 16'd0};
   localparam logic [63:0] SIZE = {16'd8, 16'd16, 16'd32, 16'd64};

   int size_of [4] = '{64, 32, 16, 8};

   logic            hclk_i = 1'b0;
   logic            rst_i;
   logic [3:0]      flush_i;
   logic            wr_en_i;
   logic [1:0]      wr_ep_i;
   logic [7:0]      wr_data_i;
   logic            wr_commit_i;
   logic            wr_abort_i;
   logic            rd_en_i;
   logic [1:0]      rd_ep_i;
   logic [7:0]      rd_data_o;
   logic            rd_valid_o;
   logic [3:0]      ep_empty_o;
   logic [3:0]      ep_full_o;
   logic [4*LW-1:0] ep_level_o;
   logic [3:0]      ovf_o;

   usbf_ep_pktbuf #(
      .EP_NUM (4), .DATA_W (8), .ADDR_W (9), .EP_BASE (BASE), .EP_SIZE (SIZE)
   ) dut (
      .hclk_i      (hclk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .wr_en_i     (wr_en_i),
      .wr_ep_i     (wr_ep_i),
      .wr_data_i   (wr_data_i),
      .wr_commit_i (wr_commit_i),
      .wr_abort_i  (wr_abort_i),
      .rd_en_i     (rd_en_i),
      .rd_ep_i     (rd_ep_i),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .ep_empty_o  (ep_empty_o),
      .ep_full_o   (ep_full_o),
      .ep_level_o  (ep_level_o),
      .ovf_o       (ovf_o)
   );

   always #5 hclk_i = ~hclk_i;

   // Reference model: committed and pending words as queues per endpoint.
   logic [7:0] cq [4][$];
   logic [7:0] pq [4][$];
   logic [3:0] m_ovf   = '0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = '0;

   int  checks = 0;
   int  errors = 0;
   bit  cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int         e;
      bit         wfull;
      logic [3:0] ovf_n;
      if (rst_i) begin
         for (int k = 0; k < 4; k++) begin
            cq[k].delete();
            pq[k].delete();
         end
         m_ovf   = '0;
         m_valid = 1'b0;
         m_data  = '0;
         return;
      end
      ovf_n   = '0;
      m_valid = 1'b0;
      e       = int'(wr_ep_i);
      wfull   = (cq[e].size() + pq[e].size() == size_of[e]);
      if (rd_en_i && !flush_i[rd_ep_i] && cq[rd_ep_i].size() != 0) begin
         m_data  = cq[rd_ep_i].pop_front();
         m_valid = 1'b1;
      end
      if (wr_en_i) begin
         if (wfull) ovf_n[e] = 1'b1;
         else       pq[e].push_back(wr_data_i);
      end
      if (wr_abort_i) pq[e].delete();
      else if (wr_commit_i)
         while (pq[e].size() != 0) cq[e].push_back(pq[e].pop_front());
      for (int k = 0; k < 4; k++) begin
         if (flush_i[k]) begin
            cq[k].delete();
            pq[k].delete();
            ovf_n[k] = 1'b0;
         end
      end
      m_ovf = ovf_n;
   endtask

   always @(negedge hclk_i) begin
      if (cmp_en) begin
         chk("rd_valid", 32'(rd_valid_o), 32'(m_valid));
         chk("rd_data", 32'(rd_data_o), 32'(m_data));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("empty%0d", k), 32'(ep_empty_o[k]), 32'(cq[k].size() == 0));
            chk($sformatf("full%0d", k), 32'(ep_full_o[k]),
                32'((cq[k].size() + pq[k].size()) == size_of[k]));
            chk($sformatf("level%0d", k), 32'(ep_level_o[k*LW +: LW]), 32'(cq[k].size()));
            chk($sformatf("ovf%0d", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
         end
      end
   end

   task automatic tick();
      @(posedge hclk_i);
      model_step();
      #1;
   endtask

   task automatic idle();
      flush_i     = '0;
      wr_en_i     = 1'b0;
      wr_ep_i     = '0;
      wr_data_i   = '0;
      wr_commit_i = 1'b0;
      wr_abort_i  = 1'b0;
      rd_en_i     = 1'b0;
      rd_ep_i     = '0;
   endtask

   task automatic op(input bit we, input int wep, input int data, input bit cm, input bit ab,
                     input bit re, input int rep, input logic [3:0] fl);
      idle();
      wr_en_i     = we;
      wr_ep_i     = 2'(wep);
      wr_data_i   = 8'(data);
      wr_commit_i = cm;
      wr_abort_i  = ab;
      rd_en_i     = re;
      rd_ep_i     = 2'(rep);
      flush_i     = fl;
      tick();
      idle();
   endtask

   task automatic wr(input int ep, input int data);  op(1, ep, data, 0, 0, 0, 0, 4'h0); endtask
   task automatic cmt(input int ep);                 op(0, ep, 0, 1, 0, 0, 0, 4'h0); endtask
   task automatic rd(input int ep);                  op(0, 0, 0, 0, 0, 1, ep, 4'h0); endtask

   task automatic rd_expect(input int ep, input int exp, input string name);
      rd(ep);
      @(negedge hclk_i);
      chk(name, 32'(rd_data_o), 32'(exp));
      chk({name, "_v"}, 32'(rd_valid_o), 32'd1);
   endtask

   initial begin
      idle();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i  = 1'b0;
      cmp_en = 1'b1;
      @(negedge hclk_i);
      chk("rst_empty", 32'(ep_empty_o), 32'hF);
      chk("rst_full", 32'(ep_full_o), 32'h0);
      chk("rst_level", 32'(ep_level_o), 32'h0);
      chk("rst_valid", 32'(rd_valid_o), 32'h0);
      chk("rst_data", 32'(rd_data_o), 32'h0);

      // Basic path on EP1
      wr(1, 'h11); wr(1, 'h22); wr(1, 'h33); cmt(1);
      @(negedge hclk_i);
      chk("basic_level", 32'(ep_level_o[1*LW +: LW]), 32'd3);
      rd_expect(1, 'h11, "basic_rd0");
      rd_expect(1, 'h22, "basic_rd1");
      rd_expect(1, 'h33, "basic_rd2");
      chk("basic_empty", 32'(ep_empty_o[1]), 32'd1);

      // Abort on EP2
      for (int i = 0; i < 5; i++) wr(2, 'hB0 + i);
      op(0, 2, 0, 0, 1, 0, 0, 4'h0);
      @(negedge hclk_i);
      chk("abort_empty", 32'(ep_empty_o[2]), 32'd1);
      wr(2, 'hA0); wr(2, 'hA1); cmt(2);
      rd_expect(2, 'hA0, "abort_rd0");
      rd_expect(2, 'hA1, "abort_rd1");
      chk("abort_drained", 32'(ep_empty_o[2]), 32'd1);

      // Full, overflow and wrap on EP0 (64 words)
      for (int i = 0; i < 64; i++) wr(0, i);
      @(negedge hclk_i);
      chk("full0", 32'(ep_full_o[0]), 32'd1);
      wr(0, 'hEE);
      @(negedge hclk_i);
      chk("ovf0_pulse", 32'(ovf_o[0]), 32'd1);
      tick();
      @(negedge hclk_i);
      chk("ovf0_clear", 32'(ovf_o[0]), 32'd0);
      cmt(0);
      for (int k = 0; k < 10; k++) rd_expect(0, k, "wrap_rd_a");
      for (int k = 0; k < 10; k++) wr(0, 100 + k);
      cmt(0);
      @(negedge hclk_i);
      chk("wrap_full", 32'(ep_full_o[0]), 32'd1);
      for (int k = 0; k < 64; k++) rd_expect(0, (k < 54) ? 10 + k : 100 + k - 54, "wrap_rd_b");

      // Simultaneous events
      wr(1, 'h55);
      op(1, 1, 'h56, 1, 0, 0, 0, 4'h0);
      @(negedge hclk_i);
      chk("cm_wr_level", 32'(ep_level_o[1*LW +: LW]), 32'd2);
      wr(1, 'h57);
      op(1, 1, 'h58, 1, 1, 0, 0, 4'h0);
      @(negedge hclk_i);
      chk("cm_ab_level", 32'(ep_level_o[1*LW +: LW]), 32'd2);
      wr(3, 'h71); wr(3, 'h72); cmt(3);
      op(1, 3, 'h73, 1, 0, 1, 3, 4'h0);
      @(negedge hclk_i);
      chk("net_level", 32'(ep_level_o[3*LW +: LW]), 32'd2);
      chk("net_rd", 32'(rd_data_o), 32'h71);
      rd_expect(1, 'h55, "sim_rd1a");
      rd_expect(1, 'h56, "sim_rd1b");
      rd_expect(3, 'h72, "sim_rd3a");
      rd_expect(3, 'h73, "sim_rd3b");

      // Flush EP1 with a same-cycle read while EP0 holds 4 words
      for (int i = 0; i < 4; i++) wr(0, 'hC0 + i);
      cmt(0);
      wr(1, 'hD0); cmt(1);
      op(0, 0, 0, 0, 0, 1, 1, 4'b0010);
      @(negedge hclk_i);
      chk("flush_valid", 32'(rd_valid_o), 32'd0);
      chk("flush_empty1", 32'(ep_empty_o[1]), 32'd1);
      chk("flush_level0", 32'(ep_level_o[0*LW +: LW]), 32'd4);
      for (int k = 0; k < 4; k++) rd_expect(0, 'hC0 + k, "flush_rd0");

      // Isolation: fill every EP to its size, interleaved
      op(0, 0, 0, 0, 0, 0, 0, 4'hF);
      for (int r = 0; r < 64; r++)
         for (int e = 0; e < 4; e++)
            if (r < size_of[e]) wr(e, (e << 6) | r);
      for (int e = 0; e < 4; e++) cmt(e);
      @(negedge hclk_i);
      chk("iso_full", 32'(ep_full_o), 32'hF);
      chk("iso_level3", 32'(ep_level_o[3*LW +: LW]), 32'd8);
      for (int e = 0; e < 4; e++)
         for (int r = 0; r < size_of[e]; r++) rd_expect(e, (e << 6) | r, "iso_rd");
      chk("iso_empty", 32'(ep_empty_o), 32'hF);

      // Randomized traffic against the model
      repeat (4000) begin
         idle();
         rst_i       = ($urandom_range(0, 599) == 0);
         wr_en_i     = ($urandom_range(0, 99) < 55);
         wr_ep_i     = 2'($urandom_range(0, 3));
         wr_data_i   = 8'($urandom);
         wr_commit_i = ($urandom_range(0, 99) < 12);
         wr_abort_i  = ($urandom_range(0, 99) < 4);
         rd_en_i     = ($urandom_range(0, 99) < 45);
         rd_ep_i     = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) flush_i[k] = ($urandom_range(0, 199) == 0);
         tick();
      end
      idle();
      rst_i = 1'b0;
      tick();
      @(negedge hclk_i);
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
